sram_bank_ctrl: RTL and testbench



---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_bank_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_bank_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the SRAM bank controller: FSM state encoding
// and the masked read-modify-write merge.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RSP   = 2'd3
  } state_e;

  // Widest bank word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MERGE_W = 64;

  function automatic logic [MERGE_W-1:0] merge_word(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] mask
  );
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/sram_bank_ctrl.sv
// Synchronous initiator for a combinational SRAM bank: one read or masked write
// per request, partial writes done as read-modify-write, one response per request.
module sram_bank_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned ADDR_BITS = $clog2(DEPTH),
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 ReqValid,
  output logic                 ReqReady,
  input  logic                 ReqWrite,
  input  logic [ADDR_BITS-1:0] ReqAddr,
  input  logic [WIDTH-1:0]     ReqData,
  input  logic [WIDTH-1:0]     ReqMask,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic [WIDTH-1:0]     RspData,
  output logic                 RspErr,
  output logic [ADDR_BITS-1:0] BankAddr,
  output logic [WIDTH-1:0]     BankWrData,
  output logic                 BankWrEn,
  input  logic [WIDTH-1:0]     BankRdData
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 rmw_q, rmw_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [WIDTH-1:0]     mask_q, mask_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [ADDR_BITS-1:0] bank_addr_q, bank_addr_d;
  logic [WIDTH-1:0]     bank_wr_data_q, bank_wr_data_d;
  logic                 bank_wr_en_q, bank_wr_en_d;
  logic                 addr_oob_c;
  logic [WIDTH-1:0]     merged_c;

  assign addr_oob_c = {1'b0, ReqAddr} >= (ADDR_BITS+1)'(DEPTH);
  assign merged_c   = WIDTH'(merge_word(MERGE_W'(BankRdData), MERGE_W'(data_q),
                                        MERGE_W'(mask_q)));

  // Next-state and registered-output decode.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rmw_d          = rmw_q;
    data_d         = data_q;
    mask_d         = mask_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_data_d     = rsp_data_q;
    rsp_err_d      = rsp_err_q;
    bank_addr_d    = bank_addr_q;
    bank_wr_data_d = '0;
    bank_wr_en_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ReqValid && req_ready_q) begin
          data_d = ReqData;
          mask_d = ReqMask;
          rmw_d  = 1'b0;
          cnt_d  = '0;
          if (addr_oob_c) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_data_d  = '0;
          end else begin
            rsp_err_d   = 1'b0;
            bank_addr_d = ReqAddr;
            if (ReqWrite && (ReqMask == '1)) begin
              state_d        = WRITE;
              bank_wr_en_d   = 1'b1;
              bank_wr_data_d = ReqData;
            end else begin
              // An all-zero mask write degenerates to a read of the stored word.
              state_d = READ;
              rmw_d   = ReqWrite && (ReqMask != '0);
            end
          end
        end
      end
      READ: begin
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          if (rmw_q) begin
            state_d        = WRITE;
            bank_wr_en_d   = 1'b1;
            bank_wr_data_d = merged_c;
          end else begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = BankRdData;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bank_wr_data_q;
      end
      RSP: begin
        if (RspReady) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rmw_q          <= 1'b0;
      data_q         <= '0;
      mask_q         <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      bank_addr_q    <= '0;
      bank_wr_data_q <= '0;
      bank_wr_en_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rmw_q          <= rmw_d;
      data_q         <= data_d;
      mask_q         <= mask_d;
      req_ready_q    <= req_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_err_q      <= rsp_err_d;
      bank_addr_q    <= bank_addr_d;
      bank_wr_data_q <= bank_wr_data_d;
      bank_wr_en_q   <= bank_wr_en_d;
    end
  end

  assign ReqReady   = req_ready_q;
  assign RspValid   = rsp_valid_q;
  assign RspData    = rsp_data_q;
  assign RspErr     = rsp_err_q;
  assign BankAddr   = bank_addr_q;
  assign BankWrData = bank_wr_data_q;
  assign BankWrEn   = bank_wr_en_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed self-checking bench for sram_bank_ctrl against a behavioural bank model.
module tb_sram_bank_ctrl;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 300;
  localparam int unsigned ABITS  = $clog2(DEPTH);
  localparam int unsigned RD_LAT = 1;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             ReqValid = 1'b0;
  logic             ReqReady;
  logic             ReqWrite = 1'b0;
  logic [ABITS-1:0] ReqAddr = '0;
  logic [WIDTH-1:0] ReqData = '0;
  logic [WIDTH-1:0] ReqMask = '0;
  logic             RspValid;
  logic             RspReady = 1'b1;
  logic [WIDTH-1:0] RspData;
  logic             RspErr;
  logic [ABITS-1:0] BankAddr;
  logic [WIDTH-1:0] BankWrData;
  logic             BankWrEn;
  logic [WIDTH-1:0] BankRdData;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int consec_we = 0;
  int bad_wd = 0;
  logic prev_we = 1'b0;

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  sram_bank_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(ABITS), .RD_LAT(RD_LAT)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqMask(ReqMask),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
    .BankAddr(BankAddr), .BankWrData(BankWrData), .BankWrEn(BankWrEn),
    .BankRdData(BankRdData)
  );

  always #5 Clk = ~Clk;

  // Combinational-read, clocked-write bank model.
  assign BankRdData = (BankAddr < DEPTH) ? mem[BankAddr] : '0;

  always @(posedge Clk) begin
    if (BankWrEn) begin
      if (BankAddr < DEPTH) mem[BankAddr] <= BankWrData;
      wr_cnt = wr_cnt + 1;
      if (prev_we) consec_we = consec_we + 1;
    end
    prev_we = BankWrEn;
  end

  always @(negedge Clk) begin
    if (!BankWrEn && BankWrData !== '0) bad_wd = bad_wd + 1;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Presents a request and returns at the first sample point after the accept edge.
  task automatic send(input logic wr, input logic [ABITS-1:0] a,
                      input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    int waited = 0;
    ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqData = d; ReqMask = m;
    while (!ReqReady && waited < 40) begin
      step();
      waited++;
    end
    vectors++;
    if (!ReqReady) begin
      miscompares++;
      $display("FAIL send_accept addr=%0d: ReqReady never rose within 40 cycles", a);
    end
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
  endtask

  // Cycle index (1 = sample just after accept edge) of the first RspValid; -1 on timeout.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!RspValid && lat < 50) begin
      step();
      lat++;
    end
    if (!RspValid) lat = -1;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({ReqReady, RspValid, RspErr, BankWrEn} !== 4'b0000 || RspData !== '0 ||
        BankAddr !== '0 || BankWrData !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: rdy=%b rv=%b err=%b we=%b rd=%h ba=%h wd=%h, all required 0",
               ReqReady, RspValid, RspErr, BankWrEn, RspData, BankAddr, BankWrData);
    end
    Rst_n = 1'b1;
    step();
    vectors++;
    if (ReqReady !== 1'b1 || BankWrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ReqReady=%b BankWrEn=%b, required 1 and 0", ReqReady, BankWrEn);
    end
  endtask

  task automatic test_full_write();
    int w0 = wr_cnt;
    send(1'b1, 5, 8'hA5, 8'hFF);
    vectors++;
    if (BankWrEn !== 1'b1 || BankWrData !== 8'hA5 || BankAddr !== 5 || RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_write_cyc1: we=%b wd=%h ba=%0d rv=%b, required 1 a5 5 0",
               BankWrEn, BankWrData, BankAddr, RspValid);
    end
    step();
    vectors++;
    if (RspValid !== 1'b1 || RspData !== 8'hA5 || RspErr !== 1'b0 || BankWrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL full_write_rsp: rv=%b rd=%h err=%b we=%b, required 1 a5 0 0",
               RspValid, RspData, RspErr, BankWrEn);
    end
    step();
    vectors++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1 || wr_cnt - w0 != 1 || mem[5] !== 8'hA5) begin
      miscompares++;
      $display("FAIL full_write_after: rv=%b rdy=%b writes=%0d mem5=%h, required 0 1 1 a5",
               RspValid, ReqReady, wr_cnt - w0, mem[5]);
    end
  endtask

  task automatic test_read(input logic [ABITS-1:0] a, input logic [WIDTH-1:0] exp_d);
    int lat;
    int w0 = wr_cnt;
    send(1'b0, a, 8'h00, 8'h00);
    wait_rsp(lat);
    vectors++;
    if (lat != 2 || RspData !== exp_d || RspErr !== 1'b0 || wr_cnt != w0) begin
      miscompares++;
      $display("FAIL read_addr%0d: lat=%0d data=%h err=%b writes=%0d, required 2 %h 0 0",
               a, lat, RspData, RspErr, wr_cnt - w0, exp_d);
    end
    step();
  endtask

  task automatic test_partial_write();
    int w0 = wr_cnt;
    send(1'b1, 5, 8'h3C, 8'h0F);
    vectors++;
    if (BankWrEn !== 1'b0 || BankAddr !== 5 || BankWrData !== '0 || RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_read_cyc: we=%b ba=%0d wd=%h rv=%b, required 0 5 00 0",
               BankWrEn, BankAddr, BankWrData, RspValid);
    end
    step();
    vectors++;
    if (BankWrEn !== 1'b1 || BankWrData !== 8'hAC || BankAddr !== 5 || RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_write_cyc: we=%b wd=%h ba=%0d rv=%b, required 1 ac 5 0",
               BankWrEn, BankWrData, BankAddr, RspValid);
    end
    step();
    vectors++;
    if (RspValid !== 1'b1 || RspData !== 8'hAC || BankWrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_rsp_lat3: rv=%b rd=%h we=%b, required 1 ac 0", RspValid, RspData, BankWrEn);
    end
    step();
    vectors++;
    if (wr_cnt - w0 != 1 || mem[5] !== 8'hAC) begin
      miscompares++;
      $display("FAIL rmw_commit: writes=%0d mem5=%h, required 1 ac", wr_cnt - w0, mem[5]);
    end
    test_read(5, 8'hAC);
  endtask

  task automatic test_mask_zero();
    int lat;
    int w0 = wr_cnt;
    send(1'b1, 5, 8'hFF, 8'h00);
    wait_rsp(lat);
    vectors++;
    if (lat != 2 || RspData !== 8'hAC || wr_cnt != w0) begin
      miscompares++;
      $display("FAIL mask_zero: lat=%0d data=%h writes=%0d, required 2 ac 0", lat, RspData, wr_cnt - w0);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    int w0;
    RspReady = 1'b0;
    send(1'b0, 5, 8'h00, 8'h00);
    wait_rsp(lat);
    w0 = wr_cnt;
    // Second request waits while the first response is stalled.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 9; ReqData = 8'h77; ReqMask = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (RspValid !== 1'b1 || RspData !== 8'hAC || ReqReady !== 1'b0 || BankWrEn !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_cyc%0d: rv=%b rd=%h rdy=%b we=%b, required 1 ac 0 0",
                 i, RspValid, RspData, ReqReady, BankWrEn);
      end
      step();
    end
    vectors++;
    if (lat != 2 || wr_cnt != w0) begin
      miscompares++;
      $display("FAIL backpressure_writes: lat=%0d writes=%0d, required 2 0", lat, wr_cnt - w0);
    end
    RspReady = 1'b1;
    step();
    vectors++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1 || BankWrEn !== 1'b0) begin
      miscompares++;
      $display("FAIL post_handshake_idle: rv=%b rdy=%b we=%b, required 0 1 0", RspValid, ReqReady, BankWrEn);
    end
    step();
    ReqValid = 1'b0;
    vectors++;
    if (BankWrEn !== 1'b1 || BankAddr !== 9 || BankWrData !== 8'h77) begin
      miscompares++;
      $display("FAIL queued_write_accept: we=%b ba=%0d wd=%h, required 1 9 77", BankWrEn, BankAddr, BankWrData);
    end
    wait_rsp(lat);
    vectors++;
    if (lat != 2 || RspData !== 8'h77) begin
      miscompares++;
      $display("FAIL queued_write_rsp: lat=%0d data=%h, required 2 77", lat, RspData);
    end
    step();
  endtask

  task automatic test_addr_error();
    int w0 = wr_cnt;
    send(1'b0, 9'd300, 8'h00, 8'h00);
    vectors++;
    if (RspValid !== 1'b1 || RspErr !== 1'b1 || RspData !== '0 || BankWrEn !== 1'b0 ||
        BankAddr !== 9) begin
      miscompares++;
      $display("FAIL addr_err_lat1: rv=%b err=%b rd=%h we=%b ba=%0d, required 1 1 00 0 9",
               RspValid, RspErr, RspData, BankWrEn, BankAddr);
    end
    step();
    vectors++;
    if (wr_cnt != w0 || RspValid !== 1'b0) begin
      miscompares++;
      $display("FAIL addr_err_after: writes=%0d rv=%b, required 0 0", wr_cnt - w0, RspValid);
    end
    test_read(9, 8'h77);
  endtask

  task automatic test_reset_mid_write();
    send(1'b1, 7, 8'h5A, 8'hFF);
    vectors++;
    if (BankWrEn !== 1'b1) begin
      miscompares++;
      $display("FAIL midwrite_we_high: BankWrEn=%b, required 1", BankWrEn);
    end
    #1 Rst_n = 1'b0;
    #1;
    vectors++;
    if (BankWrEn !== 1'b0 || BankWrData !== '0) begin
      miscompares++;
      $display("FAIL midwrite_async_drop: we=%b wd=%h, required 0 00", BankWrEn, BankWrData);
    end
    repeat (2) step();
    Rst_n = 1'b1;
    repeat (2) step();
    vectors++;
    if (RspValid !== 1'b0 || ReqReady !== 1'b1 || mem[7] !== 8'h00) begin
      miscompares++;
      $display("FAIL midwrite_after: rv=%b rdy=%b mem7=%h, required 0 1 00", RspValid, ReqReady, mem[7]);
    end
  endtask

  task automatic test_bank_invariants();
    vectors++;
    if (consec_we != 0 || bad_wd != 0) begin
      miscompares++;
      $display("FAIL bank_invariants: consecutive_we=%0d wrdata_when_idle=%0d, required 0 0",
               consec_we, bad_wd);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    #1;
    test_reset();
    test_full_write();
    test_read(5, 8'hA5);
    test_partial_write();
    test_mask_zero();
    test_backpressure();
    test_addr_error();
    test_reset_mid_write();
    test_bank_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
